// File: rtl/uart_tx_arbiter_if.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// uart_tx_arbiter_if
//   Bundles the requester handshake and the transmitter control signals that
//   sit around uart_tx_arbiter.
//
//   Signals
//     req_valid    requester i has a byte pending (held until accepted)
//     req_data     byte of requester i in bits [i*DATA_W +: DATA_W]
//     req_ready    one-hot accept from the arbiter
//     tx_start     one-cycle start pulse to the transmitter
//     tx_din       byte presented to the transmitter
//     tx_done_tick transmitter end-of-stop-bit pulse
//     busy         arbiter is not idle
//     grant_id     index of the last/current granted requester
//
//   Modports
//     slave  : the arbiter
//     master : the requesters plus transmitter side
// ----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      tx_start;
    logic [DATA_W-1:0]         tx_din;
    logic                      tx_done_tick;
    logic                      busy;
    logic [ID_W-1:0]           grant_id;

    modport slave (
        input  req_valid, req_data, tx_done_tick,
        output req_ready, tx_start, tx_din, busy, grant_id
    );

    modport master (
        output req_valid, req_data, tx_done_tick,
        input  req_ready, tx_start, tx_din, busy, grant_id
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART transmitter between NUM_REQ byte producers. A round-robin
//   search picks one requester while idle, its byte is latched and handed to
//   the transmitter with a one-cycle tx_start. The arbiter then waits for
//   tx_done_tick and, if GAP_TICKS > 0, for GAP_TICKS further s_ticks before
//   it accepts the next byte.
//
//   Parameters
//     NUM_REQ    number of requesters (2..8)
//     DATA_W     byte width, equal to the transmitter data width
//     GAP_TICKS  idle s_ticks inserted after each frame (0..255, 0 = none)
//
//   Ports
//     clk      system clock, rising edge
//     reset_n  asynchronous active-low reset
//     s_tick   16x-baud sample tick shared with the transmitter
//     bus      uart_tx_arbiter_if.slave: requester handshake, transmitter
//              start/data/done, busy and grant_id
// ----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int GAP_TICKS = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             s_tick,
    uart_tx_arbiter_if.slave bus
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GAP_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        GAP
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [GAP_W-1:0]  gap_cnt;
    logic              tx_start_q;
    logic [DATA_W-1:0] tx_din_q;
    logic [ID_W-1:0]   grant_id_q;

    logic              win_found;
    logic [ID_W-1:0]   win_id;
    int                idx;

    // Rotating priority search starting at rr_ptr. The loop runs from the
    // farthest position back to rr_ptr so the nearest valid requester is the
    // last one written and therefore wins.
    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (bus.req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    // Accept is offered only while idle; held low during reset so a pending
    // request never sees a ready while the arbiter is being cleared.
    assign bus.req_ready = (reset_n && state == IDLE && win_found)
                         ? (NUM_REQ'(1) << win_id) : '0;

    assign bus.busy     = (state != IDLE);
    assign bus.tx_start = tx_start_q;
    assign bus.tx_din   = tx_din_q;
    assign bus.grant_id = grant_id_q;

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values and the block order does not matter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            gap_cnt    <= '0;
            tx_start_q <= 1'b0;
            tx_din_q   <= '0;
            grant_id_q <= '0;
        end else begin
            tx_start_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        tx_din_q   <= bus.req_data[win_id*DATA_W +: DATA_W];
                        grant_id_q <= win_id;
                        rr_ptr     <= (win_id == ID_W'(NUM_REQ - 1))
                                    ? '0 : win_id + 1'b1;
                        // Registered pulse: high for the single START cycle.
                        tx_start_q <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.tx_done_tick) begin
                        if (GAP_TICKS > 0) begin
                            gap_cnt <= '0;
                            state   <= GAP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                GAP: begin
                    // tx_done_tick is not looked at here; only s_tick paces
                    // the gap.
                    if (s_tick) begin
                        gap_cnt <= gap_cnt + 1'b1;
                        if (gap_cnt == GAP_W'(GAP_TICKS - 1)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
